// File: rtl/lsu_access_pkg.sv
// Shared encodings for the load/store unit: FSM states, funct3 codes, strobes.
// Latency: none (declarations and one combinational helper).
// Backpressure: not applicable.
package lsu_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // RV32I funct3 access encodings (loads and stores share the size codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_B    = 4'b0001;
    localparam logic [3:0] WSTRB_H    = 4'b0011;
    localparam logic [3:0] WSTRB_W    = 4'b1111;

    // True when a request must complete with an error and never touch the bus:
    // conflicting ren/wen, unsupported funct3, or an address not naturally aligned.
    // A request with neither ren nor wen is a no-op, not a fault.
    function automatic logic access_fault(input logic       ren,
                                          input logic       wen,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (ren && wen) begin
            bad = 1'b1;
        end else if (ren) begin
            case (f3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = lo[0];
                F3_W:        bad = |lo;
                default:     bad = 1'b1;
            endcase
        end else if (wen) begin
            case (f3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = lo[0];
                F3_W:    bad = |lo;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication + strobes, load lane extract + extend.
// Latency: purely combinational.
// Backpressure: none; caller qualifies inputs and outputs.
module lsu_align
    import lsu_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_strb,
    output logic [31:0] st_lane,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // Move the addressed byte/half of the read word down to bit 0
    assign ld_shift = ld_word >> {addr_lo, 3'b000};

    // Select strobe, replicated store data and extended load value by access size
    always_comb begin
        st_strb = WSTRB_NONE;
        st_lane = 32'h0;
        ld_data = 32'h0;
        case (funct3)
            F3_B: begin
                st_strb = WSTRB_B << addr_lo;
                st_lane = {4{st_data[7:0]}};
                ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            end
            F3_H: begin
                st_strb = WSTRB_H << addr_lo;
                st_lane = {2{st_data[15:0]}};
                ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            end
            F3_W: begin
                st_strb = WSTRB_W;
                st_lane = st_data;
                ld_data = ld_word;
            end
            F3_BU: ld_data = {24'h0, ld_shift[7:0]};
            F3_HU: ld_data = {16'h0, ld_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_access.sv
// Load/store responder: one EX request -> one word-aligned strobed bus access -> WB result.
// Latency: 3 cycles accept-to-out_valid on a zero-wait bus; faults finish 1 cycle after accept.
// Backpressure: in_ready only in IDLE; result held until out_ready; bus waits bounded by TIMEOUT.
module lsu_access
    import lsu_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic [3:0]        bus_req_wstrb,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_rdata,
    input  logic              bus_resp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic              ren_q, wen_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_hit;
    logic              accept;
    logic              in_fault;
    logic              in_nop;

    logic [3:0]        al_strb;
    logic [DATA_W-1:0] al_lane;
    logic [DATA_W-1:0] al_load;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign in_fault  = access_fault(mem_ren, mem_wen, funct3, addr[1:0]);
    assign in_nop    = !mem_ren && !mem_wen;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cnt_hit   = (cnt_inc == CNT_W'(TIMEOUT));

    assign rdata = rdata_q;
    assign err   = err_q;

    // Bus payload is only driven while the request is outstanding, zero otherwise
    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_req_we    = bus_req_valid && wen_q;
    assign bus_req_addr  = bus_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_req_wdata = bus_req_we ? al_lane : '0;
    assign bus_req_wstrb = bus_req_we ? al_strb : WSTRB_NONE;

    lsu_align u_align (
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (bus_resp_rdata),
        .st_strb (al_strb),
        .st_lane (al_lane),
        .ld_data (al_load)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: faults/no-ops skip the bus; bus handshake/response beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)          state_d = (in_fault || in_nop) ? ST_DONE : ST_REQ;
            ST_REQ:  if (bus_req_ready)   state_d = ST_WAIT;
                     else if (cnt_hit)    state_d = ST_DONE;
            ST_WAIT: if (bus_resp_valid)  state_d = ST_DONE;
                     else if (cnt_hit)    state_d = ST_DONE;
            ST_DONE: if (out_ready)       state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Request capture, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        funct3_q <= funct3;
                        ren_q    <= mem_ren;
                        wen_q    <= mem_wen;
                        rdata_q  <= '0;
                        err_q    <= in_fault;
                        cnt_q    <= '0;
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        cnt_q <= '0;
                    end else if (cnt_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (bus_resp_valid) begin
                        err_q   <= bus_resp_err;
                        rdata_q <= ren_q ? al_load : '0;
                    end else if (cnt_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
// Directed bench for lsu_access with a hand-driven bus and hand-computed expectations.
// Latency: checks REQ/WAIT/DONE cycle placement and the 255-cycle timeout.
// Backpressure: exercises bus_req_ready stalls and out_ready hold.
module tb_lsu_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, mem_ren, mem_wen;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        out_valid, out_ready, err;
    logic [31:0] rdata;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid, bus_resp_err;
    logic [31:0] bus_resp_rdata;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    lsu_access dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rdata          (rdata),
        .err            (err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_we     (bus_req_we),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata),
        .bus_resp_err   (bus_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one accepting edge
    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        chk("pre.in_ready", in_ready, 32'd1);
        in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3; addr = a; wdata = wd;
        tick();
        in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        chk("post.in_ready", in_ready, 32'd0);
    endtask

    // Result held with out_ready low for one cycle, then handed off
    task automatic finish_out(input string tag, input logic [31:0] exp_rd, input logic exp_err);
        chk({tag, ".out_valid"}, out_valid, 32'd1);
        chk({tag, ".rdata"}, rdata, exp_rd);
        chk({tag, ".err"}, err, {31'd0, exp_err});
        tick();
        chk({tag, ".hold_valid"}, out_valid, 32'd1);
        chk({tag, ".hold_rdata"}, rdata, exp_rd);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_valid"}, out_valid, 32'd0);
        chk({tag, ".idle_ready"}, in_ready, 32'd1);
    endtask

    // Called in REQ right after accept: optional stall, check payload, then respond
    task automatic bus_txn(input string tag, input int stall,
                           input logic exp_we, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                           input logic [31:0] resp_rd, input logic resp_err,
                           input logic [31:0] exp_rd, input logic exp_err);
        for (int i = 0; i < stall; i++) tick();
        chk({tag, ".req_valid"}, bus_req_valid, 32'd1);
        chk({tag, ".req_we"}, bus_req_we, {31'd0, exp_we});
        chk({tag, ".req_addr"}, bus_req_addr, exp_addr);
        chk({tag, ".req_wstrb"}, bus_req_wstrb, {28'd0, exp_strb});
        chk({tag, ".req_wdata"}, bus_req_wdata, exp_wd);
        chk({tag, ".req_outv"}, out_valid, 32'd0);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        chk({tag, ".wait_reqv"}, bus_req_valid, 32'd0);
        chk({tag, ".wait_outv"}, out_valid, 32'd0);
        bus_resp_valid = 1'b1; bus_resp_rdata = resp_rd; bus_resp_err = resp_err;
        tick();
        bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
        finish_out(tag, exp_rd, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; out_ready = 1'b0; bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst.in_ready", in_ready, 32'd1);
        chk("rst.out_valid", out_valid, 32'd0);
        chk("rst.err", err, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.req_valid", bus_req_valid, 32'd0);
        chk("rst.req_we", bus_req_we, 32'd0);
        chk("rst.req_addr", bus_req_addr, 32'd0);
        chk("rst.req_wstrb", bus_req_wstrb, 32'd0);

        // SW zero-wait: accept edge, REQ, WAIT, DONE on the 3rd edge
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
        bus_txn("sw", 0, 1'b1, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0);

        // SB at byte 3 with a 2-cycle bus stall: payload must stay put
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_0012);
        bus_txn("sb", 2, 1'b1, 32'h8000_0000, 4'b1000, 32'h1212_1212, 32'h0, 1'b0, 32'h0, 1'b0);

        // SH at half 1
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0106, 32'hABCD_1234);
        bus_txn("sh", 0, 1'b1, 32'h8000_0104, 4'b1100, 32'h1234_1234, 32'h0, 1'b0, 32'h0, 1'b0);

        // Loads: sign/zero extension from selected lanes
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0);
        bus_txn("lb", 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_80FF, 1'b0, 32'hFFFF_FF80, 1'b0);
        issue(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0);
        bus_txn("lbu", 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 32'h0000_80FF, 1'b0, 32'h0000_0080, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0);
        bus_txn("lh", 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b0);
        issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0);
        bus_txn("lhu", 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 32'h8001_0000, 1'b0, 32'h0000_8001, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
        bus_txn("lw", 0, 1'b0, 32'h8000_0008, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);

        // Bus error on a load
        issue(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0);
        bus_txn("buserr", 0, 1'b0, 32'h8000_000C, 4'b0000, 32'h0, 32'h0000_00AA, 1'b1, 32'h0000_00AA, 1'b1);

        // Faults/no-ops: no bus access, out_valid right after accept
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0);
        chk("lw_mis.req_valid", bus_req_valid, 32'd0);
        finish_out("lw_mis", 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0);
        chk("ld_f3.req_valid", bus_req_valid, 32'd0);
        finish_out("ld_f3", 32'h0, 1'b1);
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h5555_5555);
        finish_out("sh_mis", 32'h0, 1'b1);
        issue(1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0);
        finish_out("both", 32'h0, 1'b1);
        issue(1'b0, 1'b0, 3'b111, 32'h8000_0003, 32'h0);
        chk("nop.req_valid", bus_req_valid, 32'd0);
        finish_out("nop", 32'h0, 1'b0);

        // Timeout with bus_req_ready low: exactly 255 REQ cycles then error
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) break;
            if (bus_req_valid) n++;
            tick();
        end
        chk("tmo.req_cycles", n, 32'd255);
        chk("tmo.req_dropped", bus_req_valid, 32'd0);
        finish_out("tmo", 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0);
        bus_txn("after_tmo", 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0, 32'h00F0_0000, 1'b0, 32'hFFFF_FFF0, 1'b0);

        // Reset in WAIT, then a late response must be ignored
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D;
        tick();
        bus_resp_valid = 1'b0; bus_resp_rdata = '0;
        chk("rstw.in_ready", in_ready, 32'd1);
        chk("rstw.out_valid", out_valid, 32'd0);
        chk("rstw.req_valid", bus_req_valid, 32'd0);
        chk("rstw.rdata", rdata, 32'd0);
        tick();
        chk("rstw.out_valid2", out_valid, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_access.md
Name: lsu_access

Overview:
Memory-side responder for the load/store requests raised by instruction decode (mem_ren/mem_wen + funct3). Accepts one request per handshake from the execute stage and performs the word-aligned bus access with byte strobes. Returns sign/zero-extended load data to writeback. Sits between the EX stage and the data-memory bus, giving the NPC a multi-cycle memory path.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; byte lanes = 4)
TIMEOUT, 255, max cycles waiting on req_ready or resp_valid before aborting with error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  EX request valid
in_ready  out  1  LSU can accept (high only in IDLE)
mem_ren  in  1  load request from decode
mem_wen  in  1  store request from decode
funct3  in  3  access size/sign (RV32I load/store encoding)
addr  in  ADDR_W  effective byte address (ALU result)
wdata  in  DATA_W  store data (rs2), LSB-aligned
out_valid  out  1  result valid to WB
out_ready  in  1  WB accepts result
rdata  out  DATA_W  extended load data; 0 for stores/non-memory
err  out  1  misaligned, illegal funct3, bus error or timeout; qualified by out_valid
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus request accepted
bus_req_we  out  1  1 = write
bus_req_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
bus_req_wdata  out  DATA_W  store data shifted to byte lane
bus_req_wstrb  out  4  byte enables (0 for reads)
bus_resp_valid  in  1  response valid
bus_resp_rdata  in  DATA_W  read word
bus_resp_err  in  1  bus error

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; in_ready 1; out_valid, err, bus_req_valid, bus_req_we 0; rdata, bus_req_addr, bus_req_wdata, bus_req_wstrb 0; timeout counter 0. Reset mid-transaction drops it; a late bus_resp_valid in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on in_valid&&in_ready, latch addr, wdata, funct3, ren, wen. Neither ren nor wen -> DONE (rdata 0, err 0). mem_ren and mem_wen both high -> DONE with err=1. Misaligned (half: addr[0]; word: addr[1:0]!=0) or illegal funct3 (load: 011/110/111; store: >=011) -> DONE, err=1, no bus access. Otherwise -> REQ.
- REQ: bus_req_valid=1, payload stable until bus_req_ready. Handshake -> WAIT, counter cleared. Same-cycle bus_resp_valid is not consumed before WAIT; the bus never responds in the accept cycle.
- WAIT: on bus_resp_valid -> DONE; err=bus_resp_err; for loads, rdata = selected lane extended; stores, rdata=0.
- Timeout: counter increments each cycle in REQ/WAIT; reaching TIMEOUT -> DONE, err=1, bus_req_valid dropped.
- DONE: out_valid=1, rdata/err stable until out_ready; handshake -> IDLE. New request accepted earliest the cycle after.
- Store strobes: SB 4'b0001<<addr[1:0], data {4{wdata[7:0]}}; SH 4'b0011<<addr[1:0], data {2{wdata[15:0]}}; SW 4'b1111, wdata.
- Load extract: byte = rdata>>(8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- Latency with zero-wait bus: accept(IDLE) -> REQ -> WAIT -> DONE = 3 cycles to out_valid.

Decomposition:
- Shared package/para include: funct3 load/store encodings, FSM state encodings, wstrb constants.
- One sub-module: lsu_align, combinational store-lane shift/strobe and load extract/extend, reused by future cache.

Test Plan:
- SW addr 0x8000_0004, wdata 0xDEADBEEF, zero-wait bus -> wstrb 1111, bus_req_addr 0x8000_0004, out_valid 3 cycles after accept, err 0.
- SB addr 0x8000_0003, wdata 0x12 -> wstrb 1000, bus_req_wdata 0x12121212.
- LB addr 0x..01, resp 0x0000_80FF -> rdata 0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr 0x..02, resp 0x8001_0000 -> 0xFFFF_8001.
- LW addr 0x..02 -> no bus_req_valid, out_valid next cycle, err 1.
- bus_req_ready held low 255 cycles -> err 1, bus_req_valid dropped; next request accepted.
- rst_n low during WAIT, then late bus_resp_valid -> stays IDLE, out_valid 0, in_ready 1.
